regfile_wb_scheduler: RTL and testbench

Sits between the execute/memory stages and the 32x64 register file's single synchronous write port. It arbitrates two writeback requesters (ALU and load unit) onto that port. It also keeps a per-register busy scoreboard, so decode stalls on RAW/WAW hazards until the producing write has landed. Decode can then use the register file's combinational read data without forwarding.

---
 rtl/regfile_pkg.sv | 29 ++
 rtl/regfile_scoreboard.sv | 66 ++++++
 rtl/regfile_wb_scheduler.sv | 121 ++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback scheduler.
// Used by both the scoreboard and the top.
package regfile_pkg;

  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 64;
  localparam int NUM_REGS   = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_MEM  = 2'd2
  } wb_src_e;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wb_req_t;

  // One-hot register mask; bit 0 is masked off by the callers because x0 never goes busy.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_WIDTH-1:0] idx);
    logic [NUM_REGS-1:0] mask;
    mask      = '0;
    mask[idx] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard with hazard detection for decode.
// It also tracks writebacks that land on registers that were never marked busy.
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_flush,
  input  logic                  i_issue_valid,
  input  logic [ADDR_WIDTH-1:0] i_issue_rd,
  input  logic [ADDR_WIDTH-1:0] i_issue_rs1,
  input  logic [ADDR_WIDTH-1:0] i_issue_rs2,
  input  logic                  i_wr_valid,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  output logic                  o_issue_stall,
  output logic [NUM_REGS-1:0]   o_busy_mask,
  output logic                  o_wb_error
);

  logic [NUM_REGS-1:0] r_busy;
  logic                r_wb_error;

  logic                w_hazard;
  logic                w_issue_fire;
  logic                w_err_hit;
  logic [NUM_REGS-1:0] w_set_mask;
  logic [NUM_REGS-1:0] w_clr_mask;
  logic [NUM_REGS-1:0] w_busy_nxt;

  always_comb begin
    w_hazard     = i_issue_valid &
                   (r_busy[i_issue_rs1] | r_busy[i_issue_rs2] | r_busy[i_issue_rd]);
    w_issue_fire = i_issue_valid & ~w_hazard & ~i_flush & (i_issue_rd != '0);
    w_set_mask   = w_issue_fire ? reg_onehot(i_issue_rd) : '0;
    w_clr_mask   = i_wr_valid ? reg_onehot(i_wr_addr) : '0;
    w_err_hit    = i_wr_valid & (i_wr_addr != '0) & ~r_busy[i_wr_addr];
  end

  // The clear is applied before the set, so a set and a clear of the same bit leave it set.
  always_comb begin
    w_busy_nxt = '0;
    if (!i_flush) begin
      w_busy_nxt = (r_busy & ~w_clr_mask) | w_set_mask;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy     <= '0;
      r_wb_error <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_err_hit) begin
        r_wb_error <= 1'b1;
      end
    end
  end

  always_comb begin
    o_issue_stall = reset | w_hazard;
    o_busy_mask   = reset ? '0 : r_busy;
    o_wb_error    = r_wb_error & ~reset;
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates ALU and load writebacks onto the single register-file write port.
// The scoreboard keeps decode stalled until each producing write has landed.
module regfile_wb_scheduler
  import regfile_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic [ADDR_WIDTH-1:0] issue_rs1,
  input  logic [ADDR_WIDTH-1:0] issue_rs2,
  output logic                  issue_stall,
  input  logic                  alu_wb_valid,
  input  logic [ADDR_WIDTH-1:0] alu_wb_addr,
  input  logic [DATA_WIDTH-1:0] alu_wb_data,
  output logic                  alu_wb_ready,
  input  logic                  mem_wb_valid,
  input  logic [ADDR_WIDTH-1:0] mem_wb_addr,
  input  logic [DATA_WIDTH-1:0] mem_wb_data,
  output logic                  mem_wb_ready,
  output logic                  rf_write_enable,
  output logic [ADDR_WIDTH-1:0] rf_write_addr,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic [NUM_REGS-1:0]   busy_mask,
  output logic                  wb_error
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  wb_req_t               w_alu_req;
  wb_req_t               w_mem_req;
  wb_src_e               w_grant;
  logic                  w_alu_force;
  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_win_addr;
  logic [DATA_WIDTH-1:0] w_win_data;

  logic [CNT_W-1:0]      r_starve_cnt;
  wb_req_t               r_out;

  always_comb begin
    w_alu_req = '{valid: alu_wb_valid, addr: alu_wb_addr, data: alu_wb_data};
    w_mem_req = '{valid: mem_wb_valid, addr: mem_wb_addr, data: mem_wb_data};
  end

  // Handshake: a requester's write is taken at the edge where its valid and ready are both
  // high. Ready is a function of both valids and the starvation counter only, never of
  // the requester's own ready, and is asserted to at most one requester per cycle.
  always_comb begin
    w_alu_force = w_alu_req.valid & (r_starve_cnt == CNT_MAX);
    w_grant     = WB_NONE;
    if (!reset) begin
      if (w_alu_force) begin
        w_grant = WB_ALU;
      end else if (w_mem_req.valid) begin
        w_grant = WB_MEM;
      end else if (w_alu_req.valid) begin
        w_grant = WB_ALU;
      end
    end
  end

  always_comb begin
    alu_wb_ready = (w_grant == WB_ALU);
    mem_wb_ready = (w_grant == WB_MEM);
    w_accept     = (w_grant != WB_NONE);
    w_win_addr   = (w_grant == WB_MEM) ? w_mem_req.addr : w_alu_req.addr;
    w_win_data   = (w_grant == WB_MEM) ? w_mem_req.data : w_alu_req.data;
  end

  // Counts consecutive cycles the ALU was kept waiting; saturates at the force-grant point.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_starve_cnt <= '0;
    end else if (!w_alu_req.valid || (w_grant == WB_ALU)) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != CNT_MAX) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  // Output stage: one registered write per accepted request, no backpressure downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out <= '0;
    end else begin
      r_out.valid <= w_accept;
      if (w_accept) begin
        r_out.addr <= w_win_addr;
        r_out.data <= w_win_data;
      end
    end
  end

  // A write still in the output stage is dropped as soon as reset is seen.
  always_comb begin
    rf_write_enable = r_out.valid & ~reset;
    rf_write_addr   = reset ? '0 : r_out.addr;
    rf_write_data   = reset ? '0 : r_out.data;
  end

  regfile_scoreboard u_scoreboard (
    .clk           (clk),
    .reset         (reset),
    .i_flush       (flush),
    .i_issue_valid (issue_valid),
    .i_issue_rd    (issue_rd),
    .i_issue_rs1   (issue_rs1),
    .i_issue_rs2   (issue_rs2),
    .i_wr_valid    (r_out.valid),
    .i_wr_addr     (r_out.addr),
    .o_issue_stall (issue_stall),
    .o_busy_mask   (busy_mask),
    .o_wb_error    (wb_error)
  );

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: directed hazard, arbitration, starvation,
// x0, error, flush and reset scenarios plus a short random issue/writeback phase.
module tb_regfile_wb_scheduler;
  import regfile_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset;
  logic                  flush;
  logic                  issue_valid;
  logic [ADDR_WIDTH-1:0] issue_rd;
  logic [ADDR_WIDTH-1:0] issue_rs1;
  logic [ADDR_WIDTH-1:0] issue_rs2;
  logic                  issue_stall;
  logic                  alu_wb_valid;
  logic [ADDR_WIDTH-1:0] alu_wb_addr;
  logic [DATA_WIDTH-1:0] alu_wb_data;
  logic                  alu_wb_ready;
  logic                  mem_wb_valid;
  logic [ADDR_WIDTH-1:0] mem_wb_addr;
  logic [DATA_WIDTH-1:0] mem_wb_data;
  logic                  mem_wb_ready;
  logic                  rf_write_enable;
  logic [ADDR_WIDTH-1:0] rf_write_addr;
  logic [DATA_WIDTH-1:0] rf_write_data;
  logic [NUM_REGS-1:0]   busy_mask;
  logic                  wb_error;

  regfile_wb_scheduler #(.STARVE_LIMIT(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .issue_valid     (issue_valid),
    .issue_rd        (issue_rd),
    .issue_rs1       (issue_rs1),
    .issue_rs2       (issue_rs2),
    .issue_stall     (issue_stall),
    .alu_wb_valid    (alu_wb_valid),
    .alu_wb_addr     (alu_wb_addr),
    .alu_wb_data     (alu_wb_data),
    .alu_wb_ready    (alu_wb_ready),
    .mem_wb_valid    (mem_wb_valid),
    .mem_wb_addr     (mem_wb_addr),
    .mem_wb_data     (mem_wb_data),
    .mem_wb_ready    (mem_wb_ready),
    .rf_write_enable (rf_write_enable),
    .rf_write_addr   (rf_write_addr),
    .rf_write_data   (rf_write_data),
    .busy_mask       (busy_mask),
    .wb_error        (wb_error)
  );

  // scoreboard
  int total = 0;
  int bad   = 0;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] e;
    if (!reset && rf_write_enable) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", 64'(rf_write_enable), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wb_addr", 64'(rf_write_addr), 64'(e[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH]));
        chk("wb_data", rf_write_data, e[DATA_WIDTH-1:0]);
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic expect_wb(input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic drive_issue(input logic [ADDR_WIDTH-1:0] rd);
    issue_valid = 1'b1;
    issue_rd    = rd;
    issue_rs1   = '0;
    issue_rs2   = '0;
    settle();
    chk("issue_free", 64'(issue_stall), 64'd0);
    step();
    issue_valid = 1'b0;
  endtask

  task automatic drive_alu(input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] d);
    alu_wb_valid = 1'b1;
    alu_wb_addr  = a;
    alu_wb_data  = d;
  endtask

  task automatic drive_mem(input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] d);
    mem_wb_valid = 1'b1;
    mem_wb_addr  = a;
    mem_wb_data  = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int m;
    logic exp_alu;
    logic [ADDR_WIDTH-1:0] r;
    logic [DATA_WIDTH-1:0] d;
    logic use_mem;

    reset = 1'b1; flush = 1'b0;
    issue_valid = 1'b0; issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
    alu_wb_valid = 1'b1; alu_wb_addr = 5'd1; alu_wb_data = 64'h1;
    mem_wb_valid = 1'b1; mem_wb_addr = 5'd2; mem_wb_data = 64'h2;
    step(); step();
    settle();
    chk("rst_stall", 64'(issue_stall), 64'd1);
    chk("rst_alu_rdy", 64'(alu_wb_ready), 64'd0);
    chk("rst_mem_rdy", 64'(mem_wb_ready), 64'd0);
    chk("rst_busy", 64'(busy_mask), 64'd0);
    chk("rst_we", 64'(rf_write_enable), 64'd0);
    alu_wb_valid = 1'b0; mem_wb_valid = 1'b0;
    reset = 1'b0;
    step();
    settle();
    chk("post_rst_busy", 64'(busy_mask), 64'd0);
    chk("post_rst_err", 64'(wb_error), 64'd0);
    chk("post_rst_we", 64'(rf_write_enable), 64'd0);
    chk("post_rst_addr", 64'(rf_write_addr), 64'd0);
    chk("post_rst_data", rf_write_data, 64'd0);
    chk("post_rst_cnt", 64'(dut.r_starve_cnt), 64'd0);

    // RAW hazard then ALU writeback clears it
    issue_valid = 1'b1; issue_rd = 5'd5; issue_rs1 = 5'd1; issue_rs2 = 5'd2;
    settle();
    chk("raw_c0_stall", 64'(issue_stall), 64'd0);
    step();
    issue_rd = 5'd6; issue_rs1 = 5'd5; issue_rs2 = 5'd0;
    settle();
    chk("raw_c1_stall", 64'(issue_stall), 64'd1);
    chk("raw_c1_busy", 64'(busy_mask), 64'h20);
    issue_valid = 1'b0;
    step();
    step();
    drive_alu(5'd5, 64'h1234);
    settle();
    chk("raw_c3_alu_rdy", 64'(alu_wb_ready), 64'd1);
    chk("raw_c3_mem_rdy", 64'(mem_wb_ready), 64'd0);
    expect_wb(5'd5, 64'h1234);
    step();
    alu_wb_valid = 1'b0;
    settle();
    chk("raw_c4_we", 64'(rf_write_enable), 64'd1);
    chk("raw_c4_busy", 64'(busy_mask), 64'h20);
    step();
    settle();
    chk("raw_c5_busy", 64'(busy_mask), 64'd0);
    issue_valid = 1'b1; issue_rd = 5'd6; issue_rs1 = 5'd5; issue_rs2 = 5'd5;
    settle();
    chk("raw_c5_stall", 64'(issue_stall), 64'd0);
    issue_valid = 1'b0;

    // simultaneous requests: load first, ALU next cycle
    drive_issue(5'd3);
    drive_issue(5'd4);
    drive_alu(5'd3, 64'hAA);
    drive_mem(5'd4, 64'hBB);
    settle();
    chk("both_mem_rdy", 64'(mem_wb_ready), 64'd1);
    chk("both_alu_rdy", 64'(alu_wb_ready), 64'd0);
    expect_wb(5'd4, 64'hBB);
    step();
    mem_wb_valid = 1'b0;
    settle();
    chk("both2_alu_rdy", 64'(alu_wb_ready), 64'd1);
    expect_wb(5'd3, 64'hAA);
    step();
    alu_wb_valid = 1'b0;
    step(); step();
    settle();
    chk("both_busy_done", 64'(busy_mask), 64'd0);

    // ALU starvation: force-granted after four lost cycles
    for (int k = 10; k <= 16; k++) drive_issue(5'(k));
    m = 0;
    drive_alu(5'd16, 64'h5A5A);
    for (int cyc = 0; cyc < 7; cyc++) begin
      mem_wb_valid = (m < 6);
      mem_wb_addr  = 5'(10 + m);
      mem_wb_data  = 64'(256 + m);
      settle();
      exp_alu = (cyc == 4);
      chk("starve_alu_rdy", 64'(alu_wb_ready), 64'(exp_alu));
      chk("starve_mem_rdy", 64'(mem_wb_ready), 64'(!exp_alu && (m < 6)));
      if (exp_alu) begin
        expect_wb(5'd16, 64'h5A5A);
      end else if (m < 6) begin
        expect_wb(5'(10 + m), 64'(256 + m));
        m++;
      end
      step();
      if (cyc == 4) begin
        alu_wb_valid = 1'b0;
        chk("starve_cnt_clr", 64'(dut.r_starve_cnt), 64'd0);
      end
    end
    mem_wb_valid = 1'b0;
    step(); step();
    settle();
    chk("starve_busy_done", 64'(busy_mask), 64'd0);

    // x0 writeback, then a stray write to non-busy x7
    drive_alu(5'd0, 64'hFF);
    settle();
    chk("x0_alu_rdy", 64'(alu_wb_ready), 64'd1);
    expect_wb(5'd0, 64'hFF);
    step();
    alu_wb_valid = 1'b0;
    settle();
    chk("x0_we", 64'(rf_write_enable), 64'd1);
    step();
    settle();
    chk("x0_busy", 64'(busy_mask), 64'd0);
    chk("x0_err", 64'(wb_error), 64'd0);
    drive_alu(5'd7, 64'h77);
    expect_wb(5'd7, 64'h77);
    step();
    alu_wb_valid = 1'b0;
    step();
    settle();
    chk("x7_err", 64'(wb_error), 64'd1);
    step(); step(); step();
    settle();
    chk("x7_err_sticky", 64'(wb_error), 64'd1);

    // flush drops a same-cycle issue and clears busy; in-flight write still lands
    drive_issue(5'd12);
    issue_valid = 1'b1; issue_rd = 5'd9; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
    flush = 1'b1;
    step();
    flush = 1'b0; issue_valid = 1'b0;
    settle();
    chk("flush_busy", 64'(busy_mask), 64'd0);
    drive_issue(5'd20);
    drive_alu(5'd20, 64'h2020);
    expect_wb(5'd20, 64'h2020);
    step();
    alu_wb_valid = 1'b0;
    flush = 1'b1;
    settle();
    chk("flush_inflight_we", 64'(rf_write_enable), 64'd1);
    step();
    flush = 1'b0;
    settle();
    chk("flush2_busy", 64'(busy_mask), 64'd0);

    // reset with a write in the output stage
    drive_issue(5'd21);
    drive_alu(5'd21, 64'h2121);
    settle();
    chk("rstmid_alu_rdy", 64'(alu_wb_ready), 64'd1);
    step();
    alu_wb_valid = 1'b0;
    reset = 1'b1;
    settle();
    chk("rstmid_gate_we", 64'(rf_write_enable), 64'd0);
    step();
    reset = 1'b0;
    settle();
    chk("rstmid_we", 64'(rf_write_enable), 64'd0);
    chk("rstmid_busy", 64'(busy_mask), 64'd0);
    chk("rstmid_err", 64'(wb_error), 64'd0);

    // random issue/writeback pairs
    for (int it = 0; it < 30; it++) begin
      r = 5'($urandom_range(31, 1));
      d = {$urandom, $urandom};
      use_mem = 1'($urandom_range(1, 0));
      drive_issue(r);
      if (use_mem) drive_mem(r, d);
      else drive_alu(r, d);
      settle();
      chk("rand_rdy", 64'(use_mem ? mem_wb_ready : alu_wb_ready), 64'd1);
      expect_wb(r, d);
      step();
      alu_wb_valid = 1'b0; mem_wb_valid = 1'b0;
      step();
      settle();
      chk("rand_busy", 64'(busy_mask), 64'd0);
    end
    chk("rand_err", 64'(wb_error), 64'd0);

    // final report
    step(); step(); step();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
